zero_run_ctrl: RTL and testbench

ZERO_RUN_CTRL -- requirements
Module: zero_run_ctrl

---
 rtl/zero_run_pkg.sv | 22 ++
 rtl/zero_run_ctrl_if.sv | 52 +++++
 rtl/zero_drain_buf.sv | 38 +++
 rtl/zero_run_ctrl.sv | 138 +++++++++++++
 tb/tb_zero_run_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/zero_run_pkg.sv
// Shared state encoding, default sizing and index-width helper for the zero-run controller.
package zero_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DEF_WIDTH     = 12;
  localparam int DEF_NIN       = 3;
  localparam int DEF_NOUT      = 9;
  localparam int DEF_MAX_STEPS = 32;

  // Width of an index over n entries; never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zero_run_ctrl_if.sv
// Host streams, core channel ports and run status of the zero-run controller.
interface zero_run_ctrl_if
  import zero_run_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NIN   = DEF_NIN,
  parameter int NOUT  = DEF_NOUT
);
  localparam int IAW = idx_w(NIN);
  localparam int CW  = idx_w(NIN + 1);
  localparam int OAW = idx_w(NOUT);

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [WIDTH-1:0] in_data;
  logic             core_reset;
  logic             core_in_we;
  logic [IAW-1:0]   core_in_addr;
  logic [WIDTH-1:0] core_in_data;
  logic [CW-1:0]    core_in_count;
  logic             core_finished;
  logic             core_success;
  logic [OAW-1:0]   core_out_addr;
  logic [WIDTH-1:0] core_out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;

  modport slave (
    input  start, in_valid, in_last, in_data, core_finished, core_success,
           core_out_data, out_ready,
    output in_ready, core_reset, core_in_we, core_in_addr, core_in_data,
           core_in_count, core_out_addr, out_valid, out_last, out_data,
           busy, done, pass, timeout
  );

  modport master (
    output start, in_valid, in_last, in_data, core_finished, core_success,
           core_out_data, out_ready,
    input  in_ready, core_reset, core_in_we, core_in_addr, core_in_data,
           core_in_count, core_out_addr, out_valid, out_last, out_data,
           busy, done, pass, timeout
  );

endinterface

// File: rtl/zero_drain_buf.sv
// Purpose: single-entry output holding register for the drain stream.
// Latency: word visible the cycle after load.
// Backpressure: word and last held stable until ready; load only when empty.
module zero_drain_buf
  import zero_run_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             fire
);

  assign fire = valid && ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (fire) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/zero_run_ctrl.sv
// Purpose: load host words into a program core, run it with a step budget, drain its outputs.
// Latency: input words written same cycle; each output word 2 cycles after its address.
// Backpressure: in_ready only while loading; drain stalls on out_ready, at most one word per 3 cycles.
module zero_run_ctrl
  import zero_run_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NIN       = DEF_NIN,
  parameter int NOUT      = DEF_NOUT,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic            clock,
  input  logic            reset,
  zero_run_ctrl_if.slave  bus
);

  localparam int IAW = idx_w(NIN);
  localparam int CW  = idx_w(NIN + 1);
  localparam int OAW = idx_w(NOUT);
  localparam int SW  = idx_w(MAX_STEPS + 1);

  state_t           state, state_nx;
  logic [CW-1:0]    load_cnt;
  logic [SW-1:0]    step_cnt;
  logic [OAW-1:0]   drain_k;
  logic             rd_pend, success_r, done_r, pass_r, timeout_r;
  logic             start_ok, accept, load_end, run_fin, run_tmo, drain_end;
  logic             buf_load, buf_valid, buf_last, buf_fire;
  logic [WIDTH-1:0] buf_data;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_ok  = 1'b0;
    accept    = 1'b0;
    load_end  = 1'b0;
    run_fin   = 1'b0;
    run_tmo   = 1'b0;
    drain_end = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          start_ok = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        accept   = bus.in_valid && (load_cnt < CW'(NIN));
        load_end = accept && (bus.in_last || (load_cnt == CW'(NIN - 1)));
        if (load_end) state_nx = S_RUN;
      end
      S_RUN: begin
        // A finish on the final budgeted step beats the timeout.
        run_fin = bus.core_finished;
        run_tmo = !bus.core_finished && (step_cnt == SW'(MAX_STEPS - 1));
        if (run_fin)      state_nx = S_DRAIN;
        else if (run_tmo) state_nx = S_DONE;
      end
      S_DRAIN: begin
        drain_end = buf_fire && buf_last;
        if (drain_end) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      load_cnt  <= '0;
      step_cnt  <= '0;
      drain_k   <= '0;
      rd_pend   <= 1'b0;
      success_r <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      if (start_ok) begin
        load_cnt  <= '0;
        step_cnt  <= '0;
        drain_k   <= '0;
        success_r <= 1'b0;
        done_r    <= 1'b0;
        pass_r    <= 1'b0;
        timeout_r <= 1'b0;
      end
      if (accept)           load_cnt <= load_cnt + CW'(1);
      if (state == S_RUN)   step_cnt <= step_cnt + SW'(1);
      if (run_fin)          success_r <= bus.core_success;
      if (run_tmo) begin
        timeout_r <= 1'b1;
        pass_r    <= 1'b0;
      end
      // The address drain_k is presented in the cycle rd_pend rises; its data lands one cycle later.
      rd_pend <= (state == S_DRAIN) && !rd_pend && !buf_valid;
      if (buf_fire && !drain_end) drain_k <= drain_k + OAW'(1);
      if (drain_end) begin
        done_r <= 1'b1;
        pass_r <= success_r;
      end
    end
  end

  assign buf_load = (state == S_DRAIN) && rd_pend;

  zero_drain_buf #(.WIDTH(WIDTH)) u_drain_buf (
    .clock     (clock),
    .reset     (reset),
    .load      (buf_load),
    .load_data (bus.core_out_data),
    .load_last (drain_k == OAW'(NOUT - 1)),
    .ready     (bus.out_ready),
    .valid     (buf_valid),
    .data      (buf_data),
    .last      (buf_last),
    .fire      (buf_fire)
  );

  assign bus.in_ready      = (state == S_LOAD) && (load_cnt < CW'(NIN));
  assign bus.core_in_we    = accept;
  assign bus.core_in_addr  = load_cnt[IAW-1:0];
  assign bus.core_in_data  = accept ? bus.in_data : '0;
  assign bus.core_in_count = load_cnt;
  assign bus.core_out_addr = drain_k;
  assign bus.core_reset    = !((state == S_RUN) || (state == S_DRAIN));
  assign bus.busy          = (state == S_LOAD) || (state == S_RUN) || (state == S_DRAIN);
  assign bus.out_valid     = buf_valid;
  assign bus.out_data      = buf_data;
  assign bus.out_last      = buf_last;
  assign bus.done          = done_r;
  assign bus.pass          = pass_r;
  assign bus.timeout       = timeout_r;

endmodule

// File: tb/tb_zero_run_ctrl.sv
// Randomised bench for zero_run_ctrl; the bench plays both host and program core.
module tb_zero_run_ctrl;
  import zero_run_pkg::*;

  localparam int W  = 12;
  localparam int NI = 3;
  localparam int NO = 9;
  localparam int MS = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  zero_run_ctrl_if #(.WIDTH(W), .NIN(NI), .NOUT(NO)) bus ();

  zero_run_ctrl #(.WIDTH(W), .NIN(NI), .NOUT(NO), .MAX_STEPS(MS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int last_hs = 0;
  logic [W-1:0] omem [NO];
  logic [W-1:0] wq [NI];
  logic [W-1:0] wr_dat_q [$];
  int           wr_adr_q [$];
  logic [W-1:0] got_q [$];
  bit           got_last_q [$];
  bit           acc, stall_prev, rst_prev;
  logic [W-1:0] stall_dat;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Samples at the falling edge, then drives core read data and out_ready just after the rising edge.
  task automatic tick();
    int ra;
    @(negedge clock);
    if (stall_prev && !rst_prev) begin
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_data", 32'(bus.out_data), 32'(stall_dat));
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    stall_dat  = bus.out_data;
    rst_prev   = reset;
    if (bus.core_in_we) begin
      wr_adr_q.push_back(int'(bus.core_in_addr));
      wr_dat_q.push_back(bus.core_in_data);
    end
    if (bus.in_valid && bus.in_ready) acc = 1'b1;
    if (bus.out_valid && bus.out_ready) begin
      if (got_q.size() > 0) chk("drain_gap", 32'((cyc - last_hs) >= 2), 1);
      last_hs = cyc;
      got_q.push_back(bus.out_data);
      got_last_q.push_back(bus.out_last);
    end
    ra = int'(bus.core_out_addr);
    @(posedge clock);
    #1;
    cyc++;
    bus.core_out_data = (ra < NO) ? omem[ra] : '0;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ((cyc % 3) == 0);
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_reset"}, 32'(bus.core_reset), 1);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_core_in_we"}, 32'(bus.core_in_we), 0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_out_last"}, 32'(bus.out_last), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_pass"}, 32'(bus.pass), 0);
    chk({tag, "_timeout"}, 32'(bus.timeout), 0);
    chk({tag, "_in_count"}, 32'(bus.core_in_count), 0);
    chk({tag, "_in_addr"}, 32'(bus.core_in_addr), 0);
    chk({tag, "_out_addr"}, 32'(bus.core_out_addr), 0);
    chk({tag, "_out_data"}, 32'(bus.out_data), 0);
  endtask

  // One host run: load wq[0..n-1], finish the core at RUN cycle fin_cyc (beyond MS = never),
  // optionally poke start mid-run, optionally reset after abort_at drained words.
  task automatic run_case(input int n, input bit use_last, input int fin_cyc, input bit succ,
                          input bit poke, input int abort_at);
    int  rc;
    bit  fin_now;
    bit  exp_fin;
    int  exp_words;
    wr_adr_q.delete();
    wr_dat_q.delete();
    got_q.delete();
    got_last_q.delete();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = wq[i];
      bus.in_last  = use_last && (i == n - 1);
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) tick();
      chk("load_accept", 32'(acc), 1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("run_entry", 32'(bus.core_reset), 0);
    chk("in_count", 32'(bus.core_in_count), 32'(n));

    rc = 1;
    for (int g = 0; g < MS + 8; g++) begin
      fin_now = (rc == fin_cyc);
      bus.core_finished = fin_now;
      bus.core_success  = succ;
      bus.start         = poke && (rc == 3);
      bus.in_valid      = 1'b1;
      bus.in_data       = W'($urandom);
      tick();
      bus.core_finished = 1'b0;
      bus.start         = 1'b0;
      if (fin_now || bus.core_reset) break;
      rc++;
    end
    bus.in_valid = 1'b0;
    exp_fin = (fin_cyc <= MS);
    if (exp_fin) chk("drain_core_reset", 32'(bus.core_reset), 0);
    else         chk("run_len", 32'(rc), 32'(MS));

    for (int t = 0; t < 400; t++) begin
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        reset = 1'b1;
        tick();
        check_reset_vals("abort");
        reset = 1'b0;
        tick();
        return;
      end
      if (!bus.busy) break;
      tick();
    end
    chk("end_busy", 32'(bus.busy), 0);

    exp_words = exp_fin ? NO : 0;
    chk("done", 32'(bus.done), 32'(exp_fin));
    chk("pass", 32'(bus.pass), 32'(exp_fin && succ));
    chk("timeout", 32'(bus.timeout), 32'(!exp_fin));
    chk("end_core_reset", 32'(bus.core_reset), 1);
    chk("word_count", 32'(got_q.size()), 32'(exp_words));
    for (int i = 0; i < got_q.size() && i < exp_words; i++) begin
      chk("word_data", 32'(got_q[i]), 32'(omem[i]));
      chk("word_last", 32'(got_last_q[i]), 32'(i == NO - 1));
    end
    chk("write_count", 32'(wr_adr_q.size()), 32'(n));
    for (int i = 0; i < wr_adr_q.size() && i < n; i++) begin
      chk("write_addr", 32'(wr_adr_q[i]), 32'(i));
      chk("write_data", 32'(wr_dat_q[i]), 32'(wq[i]));
    end
    tick();
    tick();
    chk("hold_done", 32'(bus.done), 32'(exp_fin));
    chk("hold_timeout", 32'(bus.timeout), 32'(!exp_fin));
  endtask

  task automatic load_ref_outputs();
    logic [W-1:0] ref_seq [NO];
    ref_seq = '{12'd1, 12'd2, 12'd3, 12'd3, 12'd33, 12'd2, 12'd22, 12'd1, 12'd11};
    for (int i = 0; i < NO; i++) omem[i] = ref_seq[i];
    wq[0] = 12'd33;
    wq[1] = 12'd22;
    wq[2] = 12'd11;
  endtask

  initial begin
    int n, fin;
    bit ul;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
    bus.core_finished = 1'b0;
    bus.core_success = 1'b0;
    bus.core_out_data = '0;
    bus.out_ready = 1'b1;
    stall_prev = 1'b0;
    rst_prev = 1'b1;
    stall_dat = '0;
    acc = 1'b0;
    for (int i = 0; i < NO; i++) omem[i] = '0;
    for (int i = 0; i < NI; i++) wq[i] = '0;

    repeat (3) tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    load_ref_outputs();
    rdy_mode = 0;
    run_case(3, 1'b0, 20, 1'b1, 1'b0, -1);
    rdy_mode = 1;
    run_case(3, 1'b0, 20, 1'b1, 1'b0, -1);
    wq[0] = 12'd7;
    rdy_mode = 0;
    run_case(1, 1'b1, 5, 1'b1, 1'b0, -1);
    load_ref_outputs();
    run_case(3, 1'b0, 1000, 1'b1, 1'b0, -1);
    run_case(3, 1'b0, 12, 1'b1, 1'b0, 4);
    run_case(3, 1'b1, 9, 1'b1, 1'b0, -1);
    run_case(2, 1'b1, 10, 1'b0, 1'b1, -1);
    run_case(3, 1'b0, MS, 1'b1, 1'b0, -1);

    for (int k = 0; k < 14; k++) begin
      for (int i = 0; i < NO; i++) omem[i] = W'($urandom);
      for (int i = 0; i < NI; i++) wq[i] = W'($urandom);
      n  = $urandom_range(1, NI);
      ul = (n < NI) ? 1'b1 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       fin = MS + 10;
        1:       fin = MS;
        default: fin = $urandom_range(1, MS - 1);
      endcase
      rdy_mode = $urandom_range(0, 2);
      run_case(n, ul, fin, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
